// File: rtl/xup_shift_sequencer_if.sv
// Request/response bundle for the iterating shift sequencer.
// The requester drives the operand and controls; the sequencer returns status.
interface xup_shift_sequencer_if #(
   parameter int SIZE      = 8,
   parameter int CNT_WIDTH = 3
);
   logic                 start;
   logic [SIZE-1:0]      parallel_in;
   logic                 dir;
   logic                 shift_type;
   logic [CNT_WIDTH-1:0] shift_count;
   logic                 busy;
   logic                 done;
   logic [SIZE-1:0]      parallel_out;

   modport master (
      output start,
      output parallel_in,
      output dir,
      output shift_type,
      output shift_count,
      input  busy,
      input  done,
      input  parallel_out
   );

   modport slave (
      input  start,
      input  parallel_in,
      input  dir,
      input  shift_type,
      input  shift_count,
      output busy,
      output done,
      output parallel_out
   );
endinterface

// File: rtl/xup_shift_sequencer.sv
// Registered multi-cycle shifter: one NBITS step per clock, shift_count times.
// Left shifts zero fill; right shifts fill with zero or the sign bit.
module xup_shift_sequencer #(
   parameter int SIZE      = 8,
   parameter int NBITS     = 1,
   parameter int CNT_WIDTH = 3
) (
   input logic                 clk,
   input logic                 reset_n,
   xup_shift_sequencer_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t               state_q;
   logic [SIZE-1:0]      out_q;
   logic                 dir_q;
   logic                 type_q;
   logic [CNT_WIDTH-1:0] rem_q;
   logic                 busy_q;
   logic                 done_q;

   logic [SIZE-1:0]      step_d;
   logic                 fill_d;

   // One step of the latched operation applied to the working register.
   always_comb begin
      step_d = out_q;
      fill_d = type_q & out_q[SIZE-1];
      if (dir_q) begin
         step_d = {out_q[SIZE-NBITS-1:0], {NBITS{1'b0}}};
      end else begin
         step_d = {{NBITS{fill_d}}, out_q[SIZE-1:NBITS]};
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         out_q   <= '0;
         dir_q   <= 1'b0;
         type_q  <= 1'b0;
         rem_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  out_q  <= bus.parallel_in;
                  dir_q  <= bus.dir;
                  type_q <= bus.shift_type;
                  rem_q  <= bus.shift_count;
                  busy_q <= 1'b1;
                  if (bus.shift_count == '0) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= S_SHIFT;
                  end
               end
            end
            S_SHIFT: begin
               out_q <= step_d;
               rem_q <= rem_q - 1'b1;
               if (rem_q == CNT_WIDTH'(1)) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy         = busy_q;
   assign bus.done         = done_q;
   assign bus.parallel_out = out_q;

endmodule

// File: tb/tb_xup_shift_sequencer.sv
// Self-checking bench for xup_shift_sequencer: vector table, corner
// sequences and randomized requests against an arithmetic model.
module tb_xup_shift_sequencer;

   localparam int SIZE = 8;
   localparam int NB   = 1;
   localparam int CW   = 3;

   logic clk;
   logic reset_n;

   xup_shift_sequencer_if #(.SIZE(SIZE), .CNT_WIDTH(CW)) bus ();

   xup_shift_sequencer #(
      .SIZE(SIZE), .NBITS(NB), .CNT_WIDTH(CW)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total;
   int passed;

   typedef struct {
      logic [7:0] data;
      logic       dir;
      logic       typ;
      logic [2:0] cnt;
      logic [7:0] exp_out;
   } vec_t;

   vec_t vecs [7];

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic logic [7:0] model(input logic [7:0] d, input logic dr,
                                        input logic ty, input int cnt);
      int k;
      logic signed [7:0] s;
      k = cnt * NB;
      s = d;
      if (k >= SIZE) begin
         if (!dr && ty && d[7]) return 8'hFF;
         return 8'h00;
      end
      if (dr) return d << k;
      if (ty) return 8'(s >>> k);
      return d >> k;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue a request from an idle cycle and follow it to completion.
   task automatic run_op(input string name, input logic [7:0] d,
                         input logic dr, input logic ty, input logic [2:0] c,
                         input logic [7:0] exp, input bit noise);
      int lat;
      bus.start       = 1'b1;
      bus.parallel_in = d;
      bus.dir         = dr;
      bus.shift_type  = ty;
      bus.shift_count = c;
      tick();
      bus.start = 1'b0;
      lat = 0;
      while (!bus.done && lat < 20) begin
         if (!bus.busy) check({name, " busy"}, 32'(bus.busy), 32'd1);
         if (noise && lat == 1) begin
            bus.start       = 1'b1;
            bus.parallel_in = 8'hFF;
            bus.dir         = ~dr;
            bus.shift_count = 3'd1;
         end else if (noise && lat == 2) begin
            bus.start = 1'b0;
         end
         tick();
         lat++;
      end
      bus.start = 1'b0;
      check({name, " latency"}, 32'(lat), 32'(c));
      check({name, " out"}, 32'(bus.parallel_out), 32'(exp));
      check({name, " busy@done"}, 32'(bus.busy), 32'd1);
      tick();
      check({name, " done pulse"}, 32'(bus.done), 32'd0);
      check({name, " idle"}, 32'(bus.busy), 32'd0);
      check({name, " hold"}, 32'(bus.parallel_out), 32'(exp));
   endtask

   initial begin
      total   = 0;
      passed  = 0;
      reset_n = 1'b0;
      bus.start       = 1'b1;
      bus.parallel_in = 8'hA5;
      bus.dir         = 1'b1;
      bus.shift_type  = 1'b0;
      bus.shift_count = 3'd2;

      vecs[0] = '{8'h96, 1'b1, 1'b0, 3'd3, 8'hB0};
      vecs[1] = '{8'h96, 1'b0, 1'b1, 3'd2, 8'hE5};
      vecs[2] = '{8'h96, 1'b0, 1'b0, 3'd2, 8'h25};
      vecs[3] = '{8'h5A, 1'b1, 1'b0, 3'd0, 8'h5A};
      vecs[4] = '{8'h80, 1'b0, 1'b1, 3'd7, 8'hFF};
      vecs[5] = '{8'h80, 1'b0, 1'b0, 3'd7, 8'h01};
      vecs[6] = '{8'h81, 1'b1, 1'b1, 3'd7, 8'h80};

      for (int i = 0; i < 2; i++) begin
         tick();
         check("rst out", 32'(bus.parallel_out), 32'h0);
         check("rst busy", 32'(bus.busy), 32'd0);
         check("rst done", 32'(bus.done), 32'd0);
      end
      bus.start = 1'b0;
      reset_n   = 1'b1;
      tick();
      check("post rst busy", 32'(bus.busy), 32'd0);
      check("post rst out", 32'(bus.parallel_out), 32'h0);

      for (int i = 0; i < 7; i++) begin
         run_op($sformatf("vec%0d", i), vecs[i].data, vecs[i].dir,
                vecs[i].typ, vecs[i].cnt, vecs[i].exp_out, 1'b0);
      end

      run_op("busy protect", 8'h96, 1'b1, 1'b0, 3'd3, 8'hB0, 1'b1);
      run_op("back2back", 8'h3C, 1'b0, 1'b0, 3'd1, 8'h1E, 1'b0);

      // Abort a 5-step request at its second shift edge.
      bus.start       = 1'b1;
      bus.parallel_in = 8'h96;
      bus.dir         = 1'b1;
      bus.shift_type  = 1'b0;
      bus.shift_count = 3'd5;
      tick();
      bus.start = 1'b0;
      tick();
      check("abort step1", 32'(bus.parallel_out), 32'h2C);
      reset_n = 1'b0;
      tick();
      check("abort out", 32'(bus.parallel_out), 32'h0);
      check("abort busy", 32'(bus.busy), 32'd0);
      reset_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         check("abort no done", 32'(bus.done), 32'd0);
         tick();
      end
      run_op("after abort", 8'hC3, 1'b0, 1'b1, 3'd3, 8'hF8, 1'b0);

      for (int i = 0; i < 40; i++) begin
         logic [7:0] d;
         logic       dr;
         logic       ty;
         logic [2:0] c;
         d  = 8'($urandom);
         dr = 1'($urandom);
         ty = 1'($urandom);
         c  = 3'($urandom_range(0, 7));
         run_op($sformatf("rand%0d", i), d, dr, ty, c,
                model(d, dr, ty, int'(c)), (c >= 3) && 1'($urandom));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
